// File: rtl/seq_div.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake,
// optional two's-complement mode and explicit divide-by-zero reporting.
module seq_div #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    count_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] quo_fin;
    logic [WIDTH-1:0] rem_fin;

    always_comb begin
        is_signed = SIGNED_EN && signed_mode;
        a_neg     = is_signed && a[WIDTH-1];
        b_neg     = is_signed && b[WIDTH-1];
        a_mag     = a_neg ? ('0 - a) : a;
        b_mag     = b_neg ? ('0 - b) : b;
        // The extra top bit of the trial difference is the borrow: set means restore.
        shifted   = {rem_q, dvd_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_q};
        qbit      = ~diff[WIDTH];
        rem_nxt   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt   = {dvd_q[WIDTH-2:0], qbit};
        quo_fin   = neg_quo_q ? ('0 - quo_nxt) : quo_nxt;
        rem_fin   = neg_rem_q ? ('0 - rem_nxt) : rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            count_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle, StFin: begin
                    state_q <= StIdle;
                    if (start) begin
                        if (b == '0) begin
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_q     <= StFin;
                        end else begin
                            rem_q     <= '0;
                            dvd_q     <= a_mag;
                            dvs_q     <= b_mag;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            count_q   <= CW'(WIDTH);
                            busy      <= 1'b1;
                            state_q   <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem_q   <= rem_nxt;
                    dvd_q   <= quo_nxt;
                    count_q <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        quotient    <= quo_fin;
                        remainder   <= rem_fin;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_q     <= StFin;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: scoreboard of expected results, one task per scenario.
module tb_seq_div;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    seq_div #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic sm);
        exp_t e;
        int   sx;
        int   sy;
        if (y == '0) begin
            e.q = '1;
            e.r = x;
            e.z = 1'b1;
        end else if (sm) begin
            sx = int'($signed(x));
            sy = int'($signed(y));
            if (sx == -128 && sy == -1) begin
                e.q = 8'h80;
                e.r = 8'h00;
            end else begin
                e.q = 8'(sx / sy);
                e.r = 8'(sx % sy);
            end
            e.z = 1'b0;
        end else begin
            e.q = x / y;
            e.r = x % y;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Present one request, push its expected result, return just after the accepting edge.
    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        signed_mode = sm;
        sb.push_back(model(x, y, sm));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // cyc: cycle (1-based after the accept edge) in which done is seen, -1 on timeout.
    task automatic wait_done(output int cyc, output int bcyc, output bit held);
        logic [2*W:0] snap;
        snap = {quotient, remainder, div_by_zero};
        cyc = -1;
        bcyc = 0;
        held = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                cyc = n + 1;
                break;
            end
            if (busy) bcyc++;
            if ({quotient, remainder, div_by_zero} !== snap) held = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ctrl busy/done=%b expected 00", {busy, done});
        end
        total++;
        if ({quotient, remainder, div_by_zero} !== '0) begin
            bad++;
            $display("FAIL reset_out q=%h r=%h z=%b expected 0", quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [W-1:0] xs[6] = '{8'd9, 8'd255, 8'd0, 8'd17, 8'd128, 8'd250};
        logic [W-1:0] ys[6] = '{8'd2, 8'd1, 8'd5, 8'd17, 8'd255, 8'd13};
        int cyc, bc;
        bit held;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (i < 6) drive(xs[i], ys[i], 1'b0);
            else drive(8'($urandom), 8'($urandom_range(1, 255)), 1'b0);
            wait_done(cyc, bc, held);
            e = sb.pop_front();
            total++;
            if (cyc !== 9 || bc !== 8 || !held) begin
                bad++;
                $display("FAIL u_timing[%0d] done_cyc=%0d busy_cyc=%0d held=%0b expected 9/8/1",
                         i, cyc, bc, held);
            end
            total++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                bad++;
                $display("FAIL u_result[%0d] q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         i, quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b0 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                bad++;
                $display("FAIL u_after[%0d] done=%b q=%h r=%h expected done=0 q=%h r=%h",
                         i, done, quotient, remainder, e.q, e.r);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] xs[3] = '{8'd9, 8'h80, 8'h00};
        logic         ms[3] = '{1'b0, 1'b1, 1'b0};
        int cyc, bc;
        bit held;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive(xs[i], 8'd0, ms[i]);
            wait_done(cyc, bc, held);
            e = sb.pop_front();
            total++;
            if (cyc !== 1 || bc !== 0) begin
                bad++;
                $display("FAIL dz_timing[%0d] done_cyc=%0d busy_cyc=%0d expected 1/0", i, cyc, bc);
            end
            total++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                bad++;
                $display("FAIL dz_result[%0d] q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         i, quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] xs[6] = '{8'hF9, 8'h07, 8'h80, 8'h80, 8'h81, 8'h7F};
        logic [W-1:0] ys[6] = '{8'h02, 8'hFE, 8'hFF, 8'hFF, 8'h80, 8'hF9};
        logic         ms[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        int cyc, bc;
        bit held;
        exp_t e;
        for (int i = 0; i < 18; i++) begin
            if (i < 6) drive(xs[i], ys[i], ms[i]);
            else drive(8'($urandom), 8'($urandom_range(1, 255)), 1'b1);
            wait_done(cyc, bc, held);
            e = sb.pop_front();
            total++;
            if (cyc !== 9) begin
                bad++;
                $display("FAIL s_timing[%0d] done_cyc=%0d expected 9", i, cyc);
            end
            total++;
            if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                bad++;
                $display("FAIL s_result[%0d] q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         i, quotient, remainder, div_by_zero, e.q, e.r, e.z);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        bit held;
        exp_t e;
        drive(8'd200, 8'd7, 1'b0);
        cyc = -1;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                cyc = n + 1;
                break;
            end
            // Sampled at the third edge after acceptance, while the divider is busy.
            if (n == 2) begin
                start = 1'b1;
                a = 8'd1;
                b = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        e = sb.pop_front();
        total++;
        if (cyc !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            bad++;
            $display("FAIL ignore_start done_cyc=%0d q=%0d r=%0d expected 9 q=%0d r=%0d",
                     cyc, quotient, remainder, e.q, e.r);
        end
        // Still in the done cycle: this request must be accepted at the next edge.
        drive(8'd50, 8'd6, 1'b0);
        wait_done(cyc, bc, held);
        e = sb.pop_front();
        total++;
        if (cyc !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            bad++;
            $display("FAIL fin_start done_cyc=%0d q=%0d r=%0d expected 9 q=%0d r=%0d",
                     cyc, quotient, remainder, e.q, e.r);
        end
    endtask

    task automatic test_abort();
        int cyc, bc, pulses;
        bit held;
        exp_t e;
        drive(8'd100, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            bad++;
            $display("FAIL abort_reset busy=%b done=%b q=%h r=%h z=%b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL abort_quiet active_cycles=%0d expected 0", pulses);
        end
        drive(8'd100, 8'd3, 1'b0);
        wait_done(cyc, bc, held);
        e = sb.pop_front();
        total++;
        if (cyc !== 9 || {quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
            bad++;
            $display("FAIL abort_rerun done_cyc=%0d q=%0d r=%0d expected 9 q=%0d r=%0d",
                     cyc, quotient, remainder, e.q, e.r);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_div_zero();
        test_signed();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
